// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode and state encodings
// plus the per-mode rule for a single-position step.
package usr_pkg;

  localparam logic [2:0] USR_ROL = 3'd0;
  localparam logic [2:0] USR_ROR = 3'd1;
  localparam logic [2:0] USR_SHL = 3'd2;
  localparam logic [2:0] USR_SHR = 3'd3;
  localparam logic [2:0] USR_ASR = 3'd4;

  typedef enum logic {
    USR_IDLE  = 1'b0,
    USR_SHIFT = 1'b1
  } usr_state_e;

  typedef struct packed {
    logic moved;
    logic left;
    logic in_bit;
    logic out_bit;
  } usr_step_t;

  // Width-independent part of one step: direction, entering bit and exiting bit.
  // Reserved modes report moved=0 so callers hold both data and serial output.
  function automatic usr_step_t usr_step_bits(input logic [2:0] mode, input logic msb,
                                              input logic lsb, input logic fill);
    usr_step_t s;
    s = '{moved: 1'b1, left: 1'b0, in_bit: 1'b0, out_bit: 1'b0};
    case (mode)
      USR_ROL: begin s.left = 1'b1; s.in_bit = msb;  s.out_bit = msb; end
      USR_ROR: begin s.left = 1'b0; s.in_bit = lsb;  s.out_bit = lsb; end
      USR_SHL: begin s.left = 1'b1; s.in_bit = fill; s.out_bit = msb; end
      USR_SHR: begin s.left = 1'b0; s.in_bit = fill; s.out_bit = lsb; end
      USR_ASR: begin s.left = 1'b0; s.in_bit = msb;  s.out_bit = lsb; end
      default: s.moved = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-position shifter; one instance per step of the shift chain.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [2:0]       mode_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] d_next_o,
  output logic             bit_out_o,
  output logic             moved_o
);

  usr_step_t s;

  always_comb begin
    s         = usr_step_bits(mode_i, d_i[WIDTH-1], d_i[0], fill_i);
    d_next_o  = d_i;
    if (s.moved) begin
      if (s.left) d_next_o = {d_i[WIDTH-2:0], s.in_bit};
      else        d_next_o = {s.in_bit, d_i[WIDTH-1:1]};
    end
    bit_out_o = s.out_bit;
    moved_o   = s.moved;
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift/rotate register (ROL/ROR/SHL/SHR/ASR) with start/busy/done handshake.
// Define USR_BARREL_EN to complete each shift in a single cycle through a barrel chain.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] d_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

`ifdef USR_BARREL_EN
  logic [WIDTH-1:0] stage_d     [WIDTH-1];
  logic             stage_bit   [WIDTH-1];
  logic             stage_moved [WIDTH-1];
  logic [WIDTH-1:0] barrel_d;
  logic             barrel_bit;

  // Stage g holds the register shifted by g+1 positions, fill taken live from ser_in.
  for (genvar g = 0; g < WIDTH - 1; g++) begin : g_stage
    logic [WIDTH-1:0] stage_in;
    if (g == 0) begin : g_first
      assign stage_in = data_q;
    end else begin : g_next
      assign stage_in = stage_d[g-1];
    end
    usr_step #(.WIDTH(WIDTH)) u_step (
      .d_i      (stage_in),
      .mode_i   (mode),
      .fill_i   (ser_in),
      .d_next_o (stage_d[g]),
      .bit_out_o(stage_bit[g]),
      .moved_o  (stage_moved[g])
    );
  end

  always_comb begin
    barrel_d   = data_q;
    barrel_bit = ser_q;
    for (int k = 1; k < WIDTH; k++) begin
      if (int'(amount) == k) begin
        barrel_d = stage_d[k-1];
        if (stage_moved[k-1]) barrel_bit = stage_bit[k-1];
      end
    end
  end

  always_comb begin
    data_d = data_q;
    ser_d  = ser_q;
    done_d = 1'b0;
    if (load) begin
      data_d = d_in;
    end else if (start) begin
      data_d = barrel_d;
      ser_d  = barrel_bit;
      done_d = 1'b1;
    end
  end

  assign busy = 1'b0;
`else
  usr_state_e       state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] step_d;
  logic             step_bit, step_moved;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .d_i      (data_q),
    .mode_i   (mode_q),
    .fill_i   (fill_q),
    .d_next_o (step_d),
    .bit_out_o(step_bit),
    .moved_o  (step_moved)
  );

  // Mode and fill are captured at start so the controller may change them mid-shift.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    case (state_q)
      USR_IDLE: begin
        if (load) begin
          data_d = d_in;
        end else if (start) begin
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode;
            fill_d  = ser_in;
            cnt_d   = amount;
            state_d = USR_SHIFT;
          end
        end
      end
      USR_SHIFT: begin
        if (load) begin
          data_d  = d_in;
          cnt_d   = '0;
          state_d = USR_IDLE;
        end else begin
          data_d = step_d;
          if (step_moved) ser_d = step_bit;
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = USR_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = USR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= USR_IDLE;
      cnt_q   <= '0;
      mode_q  <= USR_ROL;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  assign busy = (state_q == USR_SHIFT);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      ser_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      ser_q  <= ser_d;
      done_q <= done_d;
    end
  end

  assign d_out   = data_q;
  assign ser_out = ser_q;
  assign done    = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8): directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_universal_shift_reg;
  localparam int W = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  d_in = '0;
  logic          start = 1'b0;
  logic [2:0]    mode = '0;
  logic [AW-1:0] amount = '0;
  logic          ser_in = 1'b0;
  logic [W-1:0]  d_out;
  logic          ser_out;
  logic          busy;
  logic          done;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } exp_t;

  exp_t         expQ[$];
  int           testsRun = 0;
  int           testsFailed = 0;
  logic [W-1:0] mdlD = '0;
  logic         mdlS = 1'b0;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .d_in   (d_in),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .ser_in (ser_in),
    .d_out  (d_out),
    .ser_out(ser_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Whole multi-position shift computed at once: {last bit out, result}.
  function automatic logic [W:0] refShift(input logic [W-1:0] v, input logic s,
                                          input int m, input int n, input logic f);
    logic [31:0] x, mask, r;
    logic        o;
    x = 32'(v);
    mask = (32'd1 << W) - 1;
    if (n == 0 || m > 4) return {s, v};
    case (m)
      0:       begin r = (x << n) | (x >> (W - n)); o = v[W-n]; end
      1:       begin r = (x >> n) | (x << (W - n)); o = v[n-1]; end
      2:       begin r = (x << n) | (f ? ((32'd1 << n) - 1) : 32'd0); o = v[W-n]; end
      3:       begin r = (x >> n) | (f ? ((mask << (W - n)) & mask) : 32'd0); o = v[n-1]; end
      default: begin r = (x >> n) | (v[W-1] ? ((mask << (W - n)) & mask) : 32'd0); o = v[n-1]; end
    endcase
    return {o, r[W-1:0]};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_d_out", 32'(d_out), 32'(e.d));
        checkOutput("sb_ser_out", 32'(ser_out), 32'(e.s));
      end
    end
  end

  task automatic loadValue(input logic [W-1:0] v);
    @(negedge clk);
    load = 1'b1;
    d_in = v;
    @(negedge clk);
    load = 1'b0;
    mdlD = v;
    checkOutput("load_d_out", 32'(d_out), 32'(v));
  endtask

  task automatic applyStimulus(input int m, input int n, input logic f);
    int cycles, busyCycles, expLat, expBusy;
    logic [W:0] r;
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    mode   = 3'(m);
    amount = AW'(n);
    ser_in = f;
    r = refShift(mdlD, mdlS, m, n, f);
    mdlD = r[W-1:0];
    mdlS = r[W];
    e.d = mdlD;
    e.s = mdlS;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    busyCycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busyCycles++;
      ser_in = 1'($urandom);
      mode   = 3'($urandom);
      amount = AW'($urandom);
      start  = (busy === 1'b1) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
`ifdef USR_BARREL_EN
    expLat  = 1;
    expBusy = 0;
`else
    expLat  = (n == 0) ? 1 : n + 1;
    expBusy = n;
`endif
    checkOutput("done_latency", 32'(cycles), 32'(expLat));
    checkOutput("busy_cycles", 32'(busyCycles), 32'(expBusy));
    @(negedge clk);
    checkOutput("done_clear", 32'(done), 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_d_out", 32'(d_out), 0);
    checkOutput("reset_ser_out", 32'(ser_out), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    loadValue(8'h96);
    applyStimulus(0, 3, 1'b0);
    checkOutput("rol3_d_out", 32'(d_out), 32'h0B4);
    checkOutput("rol3_ser_out", 32'(ser_out), 0);

    loadValue(8'h96);
    applyStimulus(4, 2, 1'b0);
    checkOutput("asr2_d_out", 32'(d_out), 32'h0E5);
    checkOutput("asr2_ser_out", 32'(ser_out), 1);

    loadValue(8'h96);
    applyStimulus(1, 1, 1'b1);
    checkOutput("ror1_d_out", 32'(d_out), 32'h04B);
    checkOutput("ror1_ser_out", 32'(ser_out), 0);

    loadValue(8'h96);
    applyStimulus(2, 4, 1'b1);
    checkOutput("shl4_d_out", 32'(d_out), 32'h06F);
    checkOutput("shl4_ser_out", 32'(ser_out), 1);

    applyStimulus(0, 0, 1'b0);
    checkOutput("amt0_d_out", 32'(d_out), 32'h06F);

    // load and start together: load wins, no done
    @(negedge clk);
    load = 1'b1; start = 1'b1; d_in = 8'h11; mode = 3'd0; amount = AW'(3);
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    mdlD = 8'h11;
    checkOutput("ldst_d_out", 32'(d_out), 32'h011);
    checkOutput("ldst_done", 32'(done), 0);
    @(negedge clk);
    checkOutput("ldst_done_late", 32'(done), 0);

`ifndef USR_BARREL_EN
    // load aborts an SHR-6 at its second step
    @(negedge clk);
    start = 1'b1; mode = 3'd3; amount = AW'(6); ser_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    load = 1'b1; d_in = 8'h3C;
    begin
      logic [W:0] r;
      r = refShift(mdlD, mdlS, 3, 1, 1'b1);
      mdlS = r[W];
    end
    mdlD = 8'h3C;
    @(negedge clk);
    load = 1'b0;
    checkOutput("abort_d_out", 32'(d_out), 32'h03C);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_ser_out", 32'(ser_out), 32'(mdlS));
    @(negedge clk);
    checkOutput("abort_done_late", 32'(done), 0);

    // asynchronous reset after two steps of ROL-5
    loadValue(8'h5A);
    @(negedge clk);
    start = 1'b1; mode = 3'd0; amount = AW'(5);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
`else
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
`endif
    checkOutput("midreset_d_out", 32'(d_out), 0);
    checkOutput("midreset_ser_out", 32'(ser_out), 0);
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    mdlD = '0;
    mdlS = 1'b0;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) loadValue(W'($urandom));
      else applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, W - 1)), 1'($urandom));
      checkOutput("rand_d_out", 32'(d_out), 32'(mdlD));
      checkOutput("rand_ser_out", 32'(ser_out), 32'(mdlS));
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised shift/rotate engine that generalises the team's 8-bit left-rotate register.
- Any width.
- Five shift modes: rotate left, rotate right, logical left, logical right, arithmetic right.
- Multi-position shifts run one position per clock, under a start/busy/done handshake.
- Sits in datapath blocks that need serialisation, bit-field alignment or scrambling, driven by a local controller.

Parameters:
WIDTH, 8, register width in bits; legal range ≥2.
AMT_W, $clog2(WIDTH), width of the shift-amount input; legal amount range is 0..WIDTH-1.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
load  input  1  parallel load request.
d_in  input  WIDTH  parallel load data.
start  input  1  begin a shift operation.
mode  input  3  0=ROL, 1=ROR, 2=SHL, 3=SHR, 4=ASR, 5..7 reserved.
amount  input  AMT_W  number of positions to shift.
ser_in  input  1  fill bit for SHL/SHR.
d_out  output  WIDTH  register contents.
ser_out  output  1  last bit shifted or rotated out.
busy  output  1  operation in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
Reset and state machine
- Reset (asynchronous, any time, including mid-shift): d_out=0, ser_out=0, busy=0, done=0, state=IDLE, counter=0.
- States are IDLE and SHIFT.
- Registered busy=1 exactly while state==SHIFT.

Priority in IDLE: load > start.
- load=1: d_out<=d_in, ser_out unchanged, no done.
- start=1 and amount==0: d_out unchanged; done=1 next cycle.
- start=1 and amount>0: latch mode and ser_in into mode_q and fill_q; counter<=amount; go to SHIFT.

SHIFT state
- Each clock performs one single-position step per mode_q, then counter decrements.
- When counter==1, the step completes the operation: go to IDLE, done=1 in the following cycle.
- Latency: start sampled at edge E0; steps at edges E1..En (n=amount); busy high from after E0 to after En; done high for the cycle after En.
- start asserted during SHIFT is ignored; mode, amount and ser_in changes during SHIFT are ignored.
- load asserted during SHIFT aborts the operation: d_out<=d_in, go to IDLE, done stays 0, ser_out unchanged.

Single-position step rules
- ROL: d_out<={d_out[W-2:0],d_out[W-1]}; ser_out<=d_out[W-1].
- ROR: d_out<={d_out[0],d_out[W-1:1]}; ser_out<=d_out[0].
- SHL: d_out<={d_out[W-2:0],fill_q}; ser_out<=d_out[W-1].
- SHR: d_out<={fill_q,d_out[W-1:1]}; ser_out<=d_out[0].
- ASR: d_out<={d_out[W-1],d_out[W-1:1]}; ser_out<=d_out[0].
- Reserved modes: d_out and ser_out hold, but the counter runs and done still fires (controller timing is preserved).

done
- Single-cycle pulse; cleared the next cycle regardless of inputs.

Optional Feature:
USR_BARREL_EN
- Defined: the shift completes in one cycle through a combinational barrel network.
  - start in IDLE with any amount: d_out<=shift(d_out, mode, amount) at E0; ser_out<= last bit out (unchanged if amount==0); done=1 the cycle after E0.
  - busy is tied 0 and the SHIFT state is never entered.
  - load still has priority over start.
- Undefined: the iterative behaviour above, with no barrel logic synthesised.
- Final d_out and ser_out values are identical in both builds.

Decomposition:
- Package usr_pkg: mode encoding constants (USR_ROL, USR_ROR, USR_SHL, USR_SHR, USR_ASR), state encoding (USR_IDLE, USR_SHIFT), and a function computing a single-position step (shared by the iterative path and the barrel unroll).
- One natural sub-module, usr_step: combinational single-position shifter (d, mode, fill → d_next, bit_out).
  - Instantiated once in iterative mode.
  - Used as a chain of WIDTH-1 stages muxed by amount under USR_BARREL_EN.

Test Plan:
All scenarios use WIDTH=8.
1. Reset: reset_n low mid-SHIFT (ROL amount 5, after 2 steps) → d_out=0x00, busy=0, done=0 immediately, without waiting for a clock edge.
2. load d_in=0x96, then start ROL amount=3 → busy 3 cycles; d_out=0xB4, ser_out=0, done one pulse.
3. d_out=0x96, ASR amount=2 → d_out=0xE5, ser_out=1. Then ROR amount=1 from 0x96 → 0x4B, ser_out=0.
4. d_out=0x96, SHL amount=4, ser_in=1 (ser_in toggled to 0 during SHIFT) → d_out=0x6F, ser_out=1.
5. start with amount=0 → d_out unchanged, busy never high, done pulses the next cycle. load and start together in IDLE → load wins, no done.
6. load d_in=0x3C during SHIFT (SHR amount 6, step 2) → d_out=0x3C, state IDLE, no done. With USR_BARREL_EN, repeat scenarios 2–4 → same results, done one cycle after start, busy=0.
